// File: rtl/space_inv_pkg.sv
// Shared space-invaders types and screen geometry used by the missile pool and its slots.
package space_inv_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  typedef logic [9:0] coord_t;

  typedef enum logic {
    IDLE    = 1'b0,
    FALLING = 1'b1
  } slot_state_e;

  // 11-bit add so a coordinate pinned near 1023 saturates instead of wrapping
  function automatic coord_t sat_add(input coord_t a, input coord_t b);
    logic [10:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[10] ? 10'd1023 : sum[9:0];
  endfunction

  function automatic coord_t clamp_x(input coord_t x, input int margin);
    coord_t lo;
    coord_t hi;
    lo = coord_t'(margin);
    hi = coord_t'(SCREEN_W - 1 - margin);
    return (x < lo) ? lo : ((x > hi) ? hi : x);
  endfunction

endpackage

// File: rtl/em_slot.sv
// One enemy missile slot: IDLE/FALLING state plus position registers.
// With EM_AIM_EN defined a falling missile also drifts one pixel per frame toward ship_x.
module em_slot
  import space_inv_pkg::*;
#(
  parameter int EM_Y_STEP = 2,
  parameter int EM_Y_MAX  = 479,
  parameter int EM_SIZE   = 4
) (
  input  logic       frame_clk,
  input  logic       Reset_n,
  input  logic       alloc,
  input  logic [9:0] fire_x,
  input  logic [9:0] fire_y,
  input  logic [9:0] ship_x,
  input  logic       collided,
  output logic [9:0] em_x,
  output logic [9:0] em_y,
  output logic       exist
);

  slot_state_e state_r;
  coord_t      x_r;
  coord_t      y_r;
  coord_t      x_next_s;
  coord_t      y_next_s;
  logic [10:0] reach_s;
  logic        bottom_s;

  assign reach_s  = {1'b0, y_r} + 11'(EM_SIZE);
  assign bottom_s = (reach_s >= 11'(EM_Y_MAX));
  assign y_next_s = sat_add(y_r, coord_t'(EM_Y_STEP));

`ifdef EM_AIM_EN
  coord_t step_s;

  // One-pixel step toward the ship, then keep the sprite fully on screen
  always_comb begin
    step_s = x_r;
    if (ship_x > x_r) begin
      step_s = x_r + 10'd1;
    end else if (ship_x < x_r) begin
      step_s = x_r - 10'd1;
    end else begin
      step_s = x_r;
    end
    x_next_s = clamp_x(step_s, EM_SIZE);
  end
`else
  logic unused_ship_x_s;

  assign x_next_s        = x_r;
  assign unused_ship_x_s = ^ship_x;
`endif

  // Slot lifecycle; a retired slot keeps its last position since the renderer ignores it
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r <= IDLE;
      x_r     <= 10'd0;
      y_r     <= 10'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (alloc) begin
            state_r <= FALLING;
            x_r     <= fire_x;
            y_r     <= fire_y;
          end
        end
        FALLING: begin
          if (collided || bottom_s) begin
            state_r <= IDLE;
          end else begin
            x_r <= x_next_s;
            y_r <= y_next_s;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign em_x  = x_r;
  assign em_y  = y_r;
  assign exist = (state_r == FALLING);

endmodule

// File: rtl/enemy_missile_pool.sv
// Pool of falling alien missiles: lowest-free-slot allocator, fire cooldown and hit pulse.
// Optional aiming toward the ship is enabled by defining EM_AIM_EN.
module enemy_missile_pool
  import space_inv_pkg::*;
#(
  parameter int NUM_MISSILES  = 4,
  parameter int EM_Y_STEP     = 2,
  parameter int EM_Y_MAX      = SCREEN_H - 1,
  parameter int EM_SIZE       = 4,
  parameter int FIRE_COOLDOWN = 24
) (
  input  logic                         frame_clk,
  input  logic                         Reset_n,
  input  logic                         fire_req,
  input  logic [9:0]                   fire_x,
  input  logic [9:0]                   fire_y,
  input  logic [9:0]                   ship_x,
  input  logic [NUM_MISSILES-1:0]      collided,
  output logic                         fire_ack,
  output logic [NUM_MISSILES-1:0][9:0] emX,
  output logic [NUM_MISSILES-1:0][9:0] emY,
  output logic [NUM_MISSILES-1:0]      em_exist,
  output logic                         player_hit,
  output logic                         pool_full
);

  localparam int CD_W = (FIRE_COOLDOWN > 0) ? $clog2(FIRE_COOLDOWN + 1) : 1;

  logic [CD_W-1:0]         cooldown_r;
  logic                    accept_s;
  logic                    hit_s;
  logic                    taken_s;
  logic [NUM_MISSILES-1:0] alloc_vec_s;

  assign pool_full = &em_exist;
  assign accept_s  = fire_req & (cooldown_r == {CD_W{1'b0}}) & ~pool_full;
  assign hit_s     = |(collided & em_exist);

  // Grant the lowest-index slot that was idle before this edge
  always_comb begin
    alloc_vec_s = {NUM_MISSILES{1'b0}};
    taken_s     = 1'b0;
    for (int i = 0; i < NUM_MISSILES; i++) begin
      alloc_vec_s[i] = accept_s & ~em_exist[i] & ~taken_s;
      taken_s        = taken_s | ~em_exist[i];
    end
  end

  // Cooldown counter plus registered ack and hit pulses
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cooldown_r <= {CD_W{1'b0}};
      fire_ack   <= 1'b0;
      player_hit <= 1'b0;
    end else begin
      fire_ack   <= accept_s;
      player_hit <= hit_s;
      if (accept_s) begin
        cooldown_r <= CD_W'(FIRE_COOLDOWN);
      end else if (cooldown_r != {CD_W{1'b0}}) begin
        cooldown_r <= cooldown_r - {{(CD_W-1){1'b0}}, 1'b1};
      end else begin
        cooldown_r <= cooldown_r;
      end
    end
  end

  for (genvar g = 0; g < NUM_MISSILES; g++) begin : g_slot
    em_slot #(
      .EM_Y_STEP (EM_Y_STEP),
      .EM_Y_MAX  (EM_Y_MAX),
      .EM_SIZE   (EM_SIZE)
    ) u_slot (
      .frame_clk (frame_clk),
      .Reset_n   (Reset_n),
      .alloc     (alloc_vec_s[g]),
      .fire_x    (fire_x),
      .fire_y    (fire_y),
      .ship_x    (ship_x),
      .collided  (collided[g]),
      .em_x      (emX[g]),
      .em_y      (emY[g]),
      .exist     (em_exist[g])
    );
  end

endmodule

// File: tb/tb_enemy_missile_pool.sv
// Self-checking bench: two pools (cooldown 24 and 0) on shared stimulus, checked against
// a per-frame reference model, a directed vector table and hand-written corner sequences.
module tb_enemy_missile_pool;

  localparam int N = 4;

  logic              frame_clk = 1'b0;
  logic              Reset_n;
  logic              fire_req;
  logic [9:0]        fire_x;
  logic [9:0]        fire_y;
  logic [9:0]        ship_x;
  logic [N-1:0]      collided;

  logic              fire_ack_a, player_hit_a, pool_full_a;
  logic [N-1:0][9:0] emX_a, emY_a;
  logic [N-1:0]      em_exist_a;
  logic              fire_ack_b, player_hit_b, pool_full_b;
  logic [N-1:0][9:0] emX_b, emY_b;
  logic [N-1:0]      em_exist_b;

  int checks   = 0;
  int failures = 0;

  // reference model state, index 0 = cooldown 24 pool, index 1 = cooldown 0 pool
  int m_x[2][N];
  int m_y[2][N];
  bit m_e[2][N];
  int m_cd[2];
  bit m_ack[2];
  bit m_hit[2];

  enemy_missile_pool #(.NUM_MISSILES(N), .FIRE_COOLDOWN(24)) dut_a (
    .frame_clk(frame_clk), .Reset_n(Reset_n), .fire_req(fire_req), .fire_x(fire_x),
    .fire_y(fire_y), .ship_x(ship_x), .collided(collided), .fire_ack(fire_ack_a),
    .emX(emX_a), .emY(emY_a), .em_exist(em_exist_a), .player_hit(player_hit_a),
    .pool_full(pool_full_a));

  enemy_missile_pool #(.NUM_MISSILES(N), .FIRE_COOLDOWN(0)) dut_b (
    .frame_clk(frame_clk), .Reset_n(Reset_n), .fire_req(fire_req), .fire_x(fire_x),
    .fire_y(fire_y), .ship_x(ship_x), .collided(collided), .fire_ack(fire_ack_b),
    .emX(emX_b), .emY(emY_b), .em_exist(em_exist_b), .player_hit(player_hit_b),
    .pool_full(pool_full_b));

  always #5 frame_clk = ~frame_clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int aim(input int x, input int s);
`ifdef EM_AIM_EN
    int n;
    n = x;
    if (s > x) n = x + 1;
    else if (s < x) n = x - 1;
    if (n < 4) n = 4;
    if (n > 635) n = 635;
    return n;
`else
    return x;
`endif
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cd[k] = 0; m_ack[k] = 0; m_hit[k] = 0;
      for (int i = 0; i < N; i++) begin
        m_x[k][i] = 0; m_y[k][i] = 0; m_e[k][i] = 0;
      end
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      bit full, acc, hit;
      int slot, cdv;
      cdv  = (k == 0) ? 24 : 0;
      full = 1;
      for (int i = 0; i < N; i++) if (!m_e[k][i]) full = 0;
      acc  = fire_req && (m_cd[k] == 0) && !full;
      hit  = 0;
      slot = -1;
      for (int i = 0; i < N; i++) begin
        if (collided[i] && m_e[k][i]) hit = 1;
        if (acc && slot < 0 && !m_e[k][i]) slot = i;
      end
      for (int i = 0; i < N; i++) begin
        if (m_e[k][i]) begin
          if (collided[i] || m_y[k][i] + 4 >= 479) begin
            m_e[k][i] = 0;
          end else begin
            m_y[k][i] = (m_y[k][i] + 2 > 1023) ? 1023 : m_y[k][i] + 2;
            m_x[k][i] = aim(m_x[k][i], int'(ship_x));
          end
        end
      end
      if (slot >= 0) begin
        m_e[k][slot] = 1; m_x[k][slot] = int'(fire_x); m_y[k][slot] = int'(fire_y);
      end
      m_cd[k]  = acc ? cdv : ((m_cd[k] > 0) ? m_cd[k] - 1 : 0);
      m_ack[k] = acc;
      m_hit[k] = hit;
    end
  endtask

  task automatic compare_model();
    for (int k = 0; k < 2; k++) begin
      logic [N-1:0][9:0] ex, ey;
      logic [N-1:0]      ee;
      for (int i = 0; i < N; i++) begin
        ex[i] = 10'(m_x[k][i]); ey[i] = 10'(m_y[k][i]); ee[i] = m_e[k][i];
      end
      if (k == 0) begin
        chk("a_exist", em_exist_a, ee); chk("a_emX", emX_a, ex); chk("a_emY", emY_a, ey);
        chk("a_ack", fire_ack_a, m_ack[0]); chk("a_hit", player_hit_a, m_hit[0]);
        chk("a_full", pool_full_a, &ee);
      end else begin
        chk("b_exist", em_exist_b, ee); chk("b_emX", emX_b, ex); chk("b_emY", emY_b, ey);
        chk("b_ack", fire_ack_b, m_ack[1]); chk("b_hit", player_hit_b, m_hit[1]);
        chk("b_full", pool_full_b, &ee);
      end
    end
  endtask

  task automatic tick();
    @(posedge frame_clk);
    if (!Reset_n) model_reset();
    else model_step();
    #1;
    compare_model();
  endtask

  task automatic idle_inputs();
    fire_req = 1'b0; fire_x = 10'd0; fire_y = 10'd0; ship_x = 10'd0; collided = 4'b0000;
  endtask

  task automatic do_reset();
    Reset_n = 1'b0;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge frame_clk);
    #1;
    Reset_n = 1'b1;
  endtask

  typedef struct {
    logic       fr;
    logic [9:0] fx;
    logic [9:0] fy;
    logic [3:0] col;
    logic       e_ack;
    logic [3:0] e_exist;
    logic       e_hit;
    logic [9:0] e_y0;
  } vec_t;

  vec_t tbl[6];

  initial begin
    #200000;
    $display("FAIL timeout bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int ack_t[$];
    int k;

    // launch, fall, fire while cooling, collide on idle slot, collide on live slot
    tbl[0] = '{1'b1, 10'd100, 10'd80, 4'b0000, 1'b1, 4'b0001, 1'b0, 10'd80};
    tbl[1] = '{1'b0, 10'd0,   10'd0,  4'b0000, 1'b0, 4'b0001, 1'b0, 10'd82};
    tbl[2] = '{1'b1, 10'd200, 10'd90, 4'b0000, 1'b0, 4'b0001, 1'b0, 10'd84};
    tbl[3] = '{1'b0, 10'd0,   10'd0,  4'b0010, 1'b0, 4'b0001, 1'b0, 10'd86};
    tbl[4] = '{1'b0, 10'd0,   10'd0,  4'b0001, 1'b0, 4'b0000, 1'b1, 10'd86};
    tbl[5] = '{1'b0, 10'd0,   10'd0,  4'b0000, 1'b0, 4'b0000, 1'b0, 10'd86};

    do_reset();
    compare_model();
    chk("reset_exist", {em_exist_a, em_exist_b}, 8'h00);
    chk("reset_ack_hit", {fire_ack_a, player_hit_a, fire_ack_b, player_hit_b}, 4'h0);

    for (int r = 0; r < 6; r++) begin
      fire_req = tbl[r].fr; fire_x = tbl[r].fx; fire_y = tbl[r].fy; collided = tbl[r].col;
      tick();
      chk($sformatf("tbl%0d_ack", r), fire_ack_a, tbl[r].e_ack);
      chk($sformatf("tbl%0d_exist", r), em_exist_a, tbl[r].e_exist);
      chk($sformatf("tbl%0d_hit", r), player_hit_a, tbl[r].e_hit);
      chk($sformatf("tbl%0d_y0", r), emY_a[0], tbl[r].e_y0);
    end
    chk("tbl_x0", emX_a[0], 10'd100);

    // bottom retire: 474 -> 476 -> retired (476+4 >= 479) without a hit
    do_reset();
    fire_req = 1'b1; fire_x = 10'd50; fire_y = 10'd474;
    tick();
    chk("bot_y0", emY_a[0], 10'd474);
    fire_req = 1'b0;
    tick();
    chk("bot_y1", emY_a[0], 10'd476);
    chk("bot_live", em_exist_a[0], 1'b1);
    tick();
    chk("bot_retired", em_exist_a[0], 1'b0);
    chk("bot_hold_y", emY_a[0], 10'd476);
    chk("bot_no_hit", player_hit_a, 1'b0);

    // fill the zero-cooldown pool, then free slot 2 by collision
    do_reset();
    fire_req = 1'b1; fire_x = 10'd200; fire_y = 10'd100;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("fill_ack", fire_ack_b, 1'b1);
    end
    chk("fill_full", pool_full_b, 1'b1);
    tick();
    chk("full_no_ack", fire_ack_b, 1'b0);
    collided = 4'b0100;
    tick();
    chk("col_exist", em_exist_b, 4'b1011);
    chk("col_hit", player_hit_b, 1'b1);
    chk("col_no_reuse", fire_ack_b, 1'b0);
    collided = 4'b0000;
    tick();
    chk("reuse_ack", fire_ack_b, 1'b1);
    chk("reuse_exist", em_exist_b, 4'b1111);
    chk("reuse_y2", emY_b[2], 10'd100);
    chk("reuse_hit_off", player_hit_b, 1'b0);

    // asynchronous reset mid-flight with three live slots
    do_reset();
    fire_req = 1'b1; fire_y = 10'd50;
    repeat (3) tick();
    fire_req = 1'b0;
    chk("pre_rst_exist", em_exist_b, 4'b0111);
    #2;
    Reset_n = 1'b0;
    #1;
    chk("arst_exist", {em_exist_a, em_exist_b}, 8'h00);
    chk("arst_pos", {emY_a, emX_b, emY_b}, 120'd0);
    chk("arst_pulses", {fire_ack_a, player_hit_a, pool_full_a, fire_ack_b, player_hit_b, pool_full_b}, 6'd0);
    model_reset();
    #1;
    Reset_n = 1'b1;
    tick();

    // cooldown 24: held request acknowledged every 25 frames
    do_reset();
    fire_req = 1'b1; fire_x = 10'd320; fire_y = 10'd400;
    for (int f = 0; f < 90; f++) begin
      tick();
      if (fire_ack_a) ack_t.push_back(f);
    end
    fire_req = 1'b0;
    chk("cd_ack_count", ack_t.size(), 4);
    for (int i = 1; i < ack_t.size(); i++) chk("cd_ack_gap", ack_t[i] - ack_t[i-1], 25);

    // aiming toward ship_x (or constant X when aiming is compiled out)
    do_reset();
    fire_req = 1'b1; fire_x = 10'd300; fire_y = 10'd10; ship_x = 10'd310;
    tick();
    fire_req = 1'b0;
    chk("aim_x0", emX_a[0], 10'd300);
    for (k = 1; k < 15; k++) begin
      tick();
`ifdef EM_AIM_EN
      chk("aim_x", emX_a[0], 10'((300 + k > 310) ? 310 : 300 + k));
`else
      chk("aim_x", emX_a[0], 10'd300);
`endif
    end

    // randomized traffic against the model
    do_reset();
    for (int f = 0; f < 600; f++) begin
      fire_req = 1'($urandom % 2);
      fire_x   = 10'($urandom_range(0, 639));
      fire_y   = ($urandom % 4 == 0) ? 10'($urandom_range(460, 479)) : 10'($urandom_range(0, 479));
      ship_x   = 10'($urandom_range(0, 639));
      for (int i = 0; i < N; i++) collided[i] = ($urandom % 10 == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
